// File: rtl/bus_burst_responder.sv
// Burst-bus target: decodes an address window and serves single/burst reads and writes from local word RAM.
// Latency: first read beat WAIT_CYCLES+1 cycles after begin, end pulse the cycle after the last beat; writes take no wait states.
// Backpressure: none; every write beat is accepted (surplus beats dropped with an error pulse), reads stream one beat per cycle.
module bus_burst_responder #(
  parameter logic [31:0] BASE_ADDRESS = 32'h5000_0000,
  parameter int          MEM_WORDS    = 512,
  parameter int          WAIT_CYCLES  = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        beginTransactionIn,
  input  logic [31:0] addressDataIn,
  input  logic [7:0]  burstSizeIn,
  input  logic        readNotWriteIn,
  input  logic [3:0]  byteEnablesIn,
  input  logic        dataValidIn,
  input  logic        endTransactionIn,
  input  logic        busErrorIn,
  output logic [31:0] addressDataOut,
  output logic        dataValidOut,
  output logic        endTransactionOut,
  output logic        busErrorOut,
  output logic        busyOut
);

  localparam int AW = $clog2(MEM_WORDS);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_WAIT  = 3'd1,
    RD_BURST = 3'd2,
    RD_END   = 3'd3,
    WRITE    = 3'd4,
    ERROR    = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [AW:0]   idx_q, idx_d;       // one spare bit: index may step just past the window after the last beat
  logic [8:0]    left_q, left_d;     // beats still to transfer (burst size + 1 at begin)
  logic [3:0]    wait_q, wait_d;
  logic          dv_q, dv_d;
  logic          end_q, end_d;
  logic          err_q, err_d;
  logic [31:0]   data_q;
  logic          rd_en, wr_en;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem [MEM_WORDS];

  logic [AW:0]   begin_idx;
  logic [31:0]   end_idx;
  logic          sel, over;

  // Window is aligned to its size, so a compare of the upper address bits is an exact range check.
  assign sel       = beginTransactionIn && (addressDataIn[31:AW+2] == BASE_ADDRESS[31:AW+2]);
  assign begin_idx = {1'b0, addressDataIn[AW+1:2]};
  assign end_idx   = 32'(begin_idx) + 32'(burstSizeIn);
  assign over      = end_idx >= 32'(MEM_WORDS);

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    left_d   = left_q;
    wait_d   = wait_q;
    dv_d     = 1'b0;
    end_d    = 1'b0;
    err_d    = 1'b0;
    rd_en    = 1'b0;
    wr_en    = 1'b0;
    mem_addr = idx_q[AW-1:0];
    case (state_q)
      IDLE: begin
        if (sel) begin
          idx_d  = begin_idx;
          left_d = {1'b0, burstSizeIn} + 9'd1;
          wait_d = 4'(WAIT_CYCLES - 1);
          if (over) begin
            state_d = ERROR;
            err_d   = 1'b1;
          end else if (readNotWriteIn) begin
            state_d = RD_WAIT;
          end else begin
            state_d = WRITE;
          end
        end
      end
      RD_WAIT: begin
        if (endTransactionIn || busErrorIn) begin
          state_d = IDLE;
        end else if (wait_q == '0) begin
          // Issue the first RAM read one cycle ahead of its beat.
          rd_en   = 1'b1;
          dv_d    = 1'b1;
          idx_d   = idx_q + 1'b1;
          left_d  = left_q - 9'd1;
          state_d = RD_BURST;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      RD_BURST: begin
        if (endTransactionIn || busErrorIn) begin
          state_d = IDLE;
        end else if (left_q != '0) begin
          rd_en  = 1'b1;
          dv_d   = 1'b1;
          idx_d  = idx_q + 1'b1;
          left_d = left_q - 9'd1;
        end else begin
          end_d   = 1'b1;
          state_d = RD_END;
        end
      end
      RD_END: state_d = IDLE;
      WRITE: begin
        if (busErrorIn) begin
          state_d = IDLE;
        end else begin
          if (dataValidIn) begin
            if (left_q != '0) begin
              wr_en  = 1'b1;
              idx_d  = idx_q + 1'b1;
              left_d = left_q - 9'd1;
            end else begin
              err_d = 1'b1;
            end
          end
          if (endTransactionIn) state_d = IDLE;
        end
      end
      ERROR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counters and control outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      left_q  <= '0;
      wait_q  <= '0;
      dv_q    <= 1'b0;
      end_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      left_q  <= left_d;
      wait_q  <= wait_d;
      dv_q    <= dv_d;
      end_q   <= end_d;
      err_q   <= err_d;
    end
  end

  // Synchronous RAM read doubles as the data output register; it reads 0 when no beat is issued.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
    end else begin
      data_q <= rd_en ? mem[mem_addr] : '0;
    end
  end

  // Byte-gated RAM write; contents survive reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEnablesIn[b]) mem[mem_addr][8*b +: 8] <= addressDataIn[8*b +: 8];
      end
    end
  end

  assign addressDataOut    = data_q;
  assign dataValidOut      = dv_q;
  assign endTransactionOut = end_q;
  assign busErrorOut       = err_q;
  assign busyOut           = (state_q != IDLE);

endmodule

// File: tb/tb_bus_burst_responder.sv
// Directed and randomized checks of bus_burst_responder against a word-array model.
// Expected bus timing is derived from the transaction rules: beats at begin+1+WAIT_CYCLES, end pulse one cycle after.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_bus_burst_responder;

  localparam logic [31:0] BASE = 32'h5000_0000;
  localparam int          MW   = 512;
  localparam int          WC   = 1;

  logic        clock = 1'b0;
  logic        reset;
  logic        beginTransactionIn;
  logic [31:0] addressDataIn;
  logic [7:0]  burstSizeIn;
  logic        readNotWriteIn;
  logic [3:0]  byteEnablesIn;
  logic        dataValidIn;
  logic        endTransactionIn;
  logic        busErrorIn;
  logic [31:0] addressDataOut;
  logic        dataValidOut;
  logic        endTransactionOut;
  logic        busErrorOut;
  logic        busyOut;

  always #5 clock = ~clock;

  bus_burst_responder #(.BASE_ADDRESS(BASE), .MEM_WORDS(MW), .WAIT_CYCLES(WC)) dut (
    .clock(clock), .reset(reset),
    .beginTransactionIn(beginTransactionIn), .addressDataIn(addressDataIn),
    .burstSizeIn(burstSizeIn), .readNotWriteIn(readNotWriteIn),
    .byteEnablesIn(byteEnablesIn), .dataValidIn(dataValidIn),
    .endTransactionIn(endTransactionIn), .busErrorIn(busErrorIn),
    .addressDataOut(addressDataOut), .dataValidOut(dataValidOut),
    .endTransactionOut(endTransactionOut), .busErrorOut(busErrorOut),
    .busyOut(busyOut)
  );

  logic [31:0] model_mem [MW];
  logic [31:0] wdat [256];
  logic [3:0]  wbe  [256];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [35:0] obs();
    return {dataValidOut, endTransactionOut, busErrorOut, busyOut, addressDataOut};
  endfunction

  function automatic logic [35:0] pat(input bit dv, input bit en, input bit er, input bit by, input logic [31:0] d);
    return {dv, en, er, by, d};
  endfunction

  task automatic check(input string tag, input logic [35:0] o, input logic [35:0] e);
    n_checks++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed {dv,end,err,busy,data}=%h expected %h", tag, o, e);
    end
  endtask

  function automatic void mwrite(input int i, input logic [31:0] d, input logic [3:0] be);
    for (int b = 0; b < 4; b++) if (be[b]) model_mem[i][8*b +: 8] = d[8*b +: 8];
  endfunction

  task automatic quiet();
    beginTransactionIn = 0; addressDataIn = 0; burstSizeIn = 0; readNotWriteIn = 0;
    byteEnablesIn = 0; dataValidIn = 0; endTransactionIn = 0; busErrorIn = 0;
  endtask

  // Irrelevant activity while a read is in flight: begins must be ignored by a busy target.
  task automatic noise();
    beginTransactionIn = 1'($urandom_range(0, 1));
    addressDataIn      = BASE + 32'($urandom_range(0, MW - 1) * 4);
    burstSizeIn        = 8'($urandom);
    readNotWriteIn     = 1'($urandom_range(0, 1));
    dataValidIn        = 1'($urandom_range(0, 1));
  endtask

  task automatic start(input int idx, input int bsz, input bit rnw);
    beginTransactionIn = 1;
    addressDataIn      = BASE + 32'(idx * 4) + 32'($urandom_range(0, 3));
    burstSizeIn        = 8'(bsz);
    readNotWriteIn     = rnw;
    tick();
    quiet();
  endtask

  task automatic fill_wdat(input int nb, input bit full_be);
    for (int k = 0; k < nb; k++) begin
      wdat[k] = $urandom;
      wbe[k]  = full_be ? 4'hF : 4'($urandom);
    end
  endtask

  // abort_after = number of beats seen before abort (0 = run to completion)
  task automatic rd_burst(input int idx, input int bsz, input int abort_after, input bit use_err);
    start(idx, bsz, 1'b1);
    for (int c = 0; c < WC; c++) begin
      check($sformatf("rd wait %0d idx %0d", c, idx), obs(), pat(0, 0, 0, 1, 0));
      noise(); tick(); quiet();
    end
    for (int k = 0; k <= bsz; k++) begin
      check($sformatf("rd beat %0d idx %0d", k, idx + k), obs(), pat(1, 0, 0, 1, model_mem[idx + k]));
      if (k + 1 == abort_after) begin
        if (use_err) busErrorIn = 1; else endTransactionIn = 1;
        noise(); tick(); quiet();
        check($sformatf("rd abort idx %0d", idx), obs(), pat(0, 0, 0, 0, 0));
        return;
      end
      noise(); tick(); quiet();
    end
    check($sformatf("rd end idx %0d", idx), obs(), pat(0, 1, 0, 1, 0));
    tick();
    check($sformatf("rd idle idx %0d", idx), obs(), pat(0, 0, 0, 0, 0));
  endtask

  // err_at = beat index carrying busErrorIn (-1 = none)
  task automatic wr_burst(input int idx, input int bsz, input int nb, input bit end_same, input int err_at);
    bit last;
    start(idx, bsz, 1'b0);
    check($sformatf("wr start idx %0d", idx), obs(), pat(0, 0, 0, 1, 0));
    for (int k = 0; k < nb; k++) begin
      last             = (k == nb - 1);
      dataValidIn      = 1;
      addressDataIn    = wdat[k];
      byteEnablesIn    = wbe[k];
      endTransactionIn = end_same && last;
      busErrorIn       = (k == err_at);
      if (k <= bsz && k != err_at) mwrite(idx + k, wdat[k], wbe[k]);
      tick(); quiet();
      if (k == err_at) begin
        check($sformatf("wr buserr abort idx %0d", idx), obs(), pat(0, 0, 0, 0, 0));
        return;
      end
      check($sformatf("wr beat %0d idx %0d", k, idx), obs(), pat(0, 0, k > bsz, !(end_same && last), 0));
    end
    if (!end_same) begin
      endTransactionIn = 1;
      tick(); quiet();
      check($sformatf("wr end idx %0d", idx), obs(), pat(0, 0, 0, 0, 0));
    end
  endtask

  task automatic rng_err(input int idx, input int bsz, input bit rnw);
    start(idx, bsz, rnw);
    check($sformatf("range err pulse idx %0d bsz %0d", idx, bsz), obs(), pat(0, 0, 1, 1, 0));
    tick();
    check($sformatf("range err idle idx %0d", idx), obs(), pat(0, 0, 0, 0, 0));
  endtask

  task automatic unsel(input logic [31:0] addr);
    beginTransactionIn = 1; addressDataIn = addr; readNotWriteIn = 1;
    tick(); quiet();
    check($sformatf("unselected %h c1", addr), obs(), pat(0, 0, 0, 0, 0));
    tick();
    check($sformatf("unselected %h c2", addr), obs(), pat(0, 0, 0, 0, 0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, observed timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, bsz, nb;
    bit rnw;

    reset = 0;
    quiet();
    repeat (3) tick();
    check("reset state", obs(), pat(0, 0, 0, 0, 0));
    reset = 1;
    tick();
    check("post reset idle", obs(), pat(0, 0, 0, 0, 0));

    // Fill the whole memory so every read has a known model value.
    fill_wdat(256, 1'b1); wr_burst(0, 255, 256, 1'b1, -1);
    fill_wdat(256, 1'b1); wr_burst(256, 255, 256, 1'b1, -1);

    // Single word write/readback at BASE+0x10.
    wdat[0] = 32'hDEADBEEF; wbe[0] = 4'hF;
    wr_burst(4, 0, 1, 1'b1, -1);
    rd_burst(4, 0, 0, 1'b0);

    // Eight-beat burst at BASE+0x40.
    for (int k = 0; k < 8; k++) begin wdat[k] = 32'(k); wbe[k] = 4'hF; end
    wr_burst(16, 7, 8, 1'b0, -1);
    rd_burst(16, 7, 0, 1'b0);

    // Byte enables.
    wdat[0] = 32'hFFFFFFFF; wbe[0] = 4'hF;   wr_burst(8, 0, 1, 1'b1, -1);
    wdat[0] = 32'h11223344; wbe[0] = 4'b0101; wr_burst(8, 0, 1, 1'b1, -1);
    rd_burst(8, 0, 0, 1'b0);

    // Window edges and range check.
    rng_err(MW - 2, 2, 1'b1);
    rng_err(MW - 1, 1, 1'b0);
    rd_burst(MW - 3, 2, 0, 1'b0);
    rd_burst(MW - 1, 0, 0, 1'b0);
    unsel(BASE - 32'd4);
    unsel(BASE + 32'(MW * 4));

    // Aborted reads followed by a clean read.
    rd_burst(100, 15, 3, 1'b0);
    rd_burst(100, 15, 0, 1'b0);
    rd_burst(200, 5, 2, 1'b1);
    rd_burst(200, 5, 0, 1'b0);

    // Surplus write beat dropped; the word after the burst is untouched.
    fill_wdat(3, 1'b1);
    wr_burst(40, 1, 3, 1'b0, -1);
    rd_burst(40, 2, 0, 1'b0);

    // busErrorIn during a write discards that beat.
    fill_wdat(4, 1'b1);
    wr_burst(60, 3, 4, 1'b0, 1);
    rd_burst(60, 3, 0, 1'b0);

    // Reset in the middle of a read burst clears outputs without a clock edge.
    start(120, 7, 1'b1);
    tick();
    check("rst-rd beat0", obs(), pat(1, 0, 0, 1, model_mem[120]));
    tick();
    check("rst-rd beat1", obs(), pat(1, 0, 0, 1, model_mem[121]));
    #2 reset = 0;
    #1;
    check("async reset mid read", obs(), pat(0, 0, 0, 0, 0));
    tick();
    reset = 1;
    tick();
    check("idle after mid-read reset", obs(), pat(0, 0, 0, 0, 0));

    // Reset in the middle of a write burst keeps the beats already written.
    start(300, 3, 1'b0);
    for (int k = 0; k < 2; k++) begin
      dataValidIn = 1; addressDataIn = $urandom; byteEnablesIn = 4'hF;
      mwrite(300 + k, addressDataIn, 4'hF);
      tick(); quiet();
    end
    dataValidIn = 1; addressDataIn = $urandom; byteEnablesIn = 4'hF;
    #2 reset = 0;
    #1;
    check("async reset mid write", obs(), pat(0, 0, 0, 0, 0));
    tick(); quiet();
    reset = 1;
    tick();
    rd_burst(300, 3, 0, 1'b0);

    // Randomized transactions.
    for (int it = 0; it < 30; it++) begin
      idx = $urandom_range(0, MW - 1);
      bsz = $urandom_range(0, 20);
      rnw = 1'($urandom_range(0, 1));
      if (idx + bsz >= MW) begin
        rng_err(idx, bsz, rnw);
      end else if (rnw) begin
        rd_burst(idx, bsz, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, bsz + 1)) : 0,
                 1'($urandom_range(0, 1)));
      end else begin
        nb = $urandom_range(1, bsz + 3);
        fill_wdat(nb, 1'b0);
        wr_burst(idx, bsz, nb, (nb <= bsz + 1) ? 1'($urandom_range(0, 1)) : 1'b0, -1);
        rd_burst(idx, bsz, 0, 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
